// File: rtl/spram_pkg.sv
// rtl/spram_pkg.sv - shared sizes, types and operation codes for the SPRAM environment
// Ports: none (package).
package spram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 65536;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // Decoded access type, shared by RTL, driver, monitor and scoreboard.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

endpackage

// File: rtl/spram_core.sv
// rtl/spram_core.sv - bare single-port storage array with synchronous write and raw read port
// Ports:
//   clk     in   clock, write on rising edge
//   we      in   write strobe (already qualified by enable/range/reset)
//   addr    in   word address shared by write and read
//   wdata   in   write data
//   rdata   out  unregistered array contents at addr (registered by the wrapper)
module spram_core
    import spram_pkg::*;
#(
    parameter int CORE_ADDR_W = ADDR_W,
    parameter int CORE_DATA_W = DATA_W,
    parameter int CORE_DEPTH  = DEPTH
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [CORE_ADDR_W-1:0] addr,
    input  logic [CORE_DATA_W-1:0] wdata,
    output logic [CORE_DATA_W-1:0] rdata
);

    // No reset on the array so it maps onto a memory macro / inferred RAM.
    logic [CORE_DATA_W-1:0] mem [CORE_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(addr) < CORE_DEPTH) begin
            rdata = mem[addr];
        end
    end

endmodule

// File: rtl/modport_ram.sv
// rtl/modport_ram.sv - single-port synchronous RAM with enable gating, range check and registered read data
// Ports:
//   clk     in   clock, all activity on rising edge
//   reset   in   asynchronous active-low reset; clears rdata, blocks accesses
//   addr    in   word address
//   wen     in   1 = write, 0 = read (only when me=1)
//   me      in   memory enable; 0 = no operation
//   wdata   in   write data
//   rdata   out  registered read data, 1-cycle latency
module modport_ram
    import spram_pkg::*;
#(
    parameter int RAM_ADDR_W = ADDR_W,
    parameter int RAM_DATA_W = DATA_W,
    parameter int RAM_DEPTH  = DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RAM_ADDR_W-1:0] addr,
    input  logic                  wen,
    input  logic                  me,
    input  logic [RAM_DATA_W-1:0] wdata,
    output logic [RAM_DATA_W-1:0] rdata
);

    op_e                   op;
    logic                  in_range;
    logic                  core_we;
    logic [RAM_DATA_W-1:0] core_rdata;
    logic [RAM_DATA_W-1:0] rdata_d;
    logic [RAM_DATA_W-1:0] rdata_q;

    // Constant-true when the array fills the whole address space.
    assign in_range = (32'(addr) < RAM_DEPTH);

    // An X on me fails the if-test and decodes as idle.
    always_comb begin
        op = OP_IDLE;
        if (me) begin
            op = wen ? OP_WRITE : OP_READ;
        end
    end

    // Gating with reset keeps the array untouched on any edge seen while reset is low.
    assign core_we = reset && (op == OP_WRITE) && in_range;

    spram_core #(
        .CORE_ADDR_W (RAM_ADDR_W),
        .CORE_DATA_W (RAM_DATA_W),
        .CORE_DEPTH  (RAM_DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (core_rdata)
    );

    // rdata only changes on a read; writes and idle cycles hold it.
    always_comb begin
        rdata_d = rdata_q;
        if (op == OP_READ) begin
            rdata_d = in_range ? core_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    a_ctrl_known : assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(me) && (!me || !$isunknown(wen)));

endmodule

// File: tb/tb_modport_ram.sv
// tb/tb_modport_ram.sv - directed self-checking bench for modport_ram
module tb_modport_ram;
    import spram_pkg::*;

    logic  clk;
    logic  reset;
    addr_t addr;
    logic  wen;
    logic  me;
    data_t wdata;
    data_t rdata;

    int total;
    int bad;

    modport_ram dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wen   (wen),
        .me    (me),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input data_t got, input data_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; drives one access, returns at posedge+1 after its sampling edge.
    task automatic access(input logic m, input logic w, input addr_t a, input data_t d);
        me    = m;
        wen   = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        me  = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        me    = 1'b0;
        wen   = 1'b0;
        addr  = '0;
        wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", rdata, 64'h0);
        reset = 1'b1;

        // Load rdata with all ones so the async clear is visible.
        access(1'b1, 1'b1, 16'h0005, 64'hFFFF_FFFF_FFFF_FFFF);
        access(1'b1, 1'b0, 16'h0005, 64'h0);
        check_eq("pre_reset_read", rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        #3;
        reset = 1'b0;
        #1;
        check_eq("async_clear", rdata, 64'h0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_hold", rdata, 64'h0);
        access(1'b0, 1'b0, 16'h0005, 64'h0);
        check_eq("release_idle", rdata, 64'h0);

        access(1'b1, 1'b1, 16'h0010, 64'hDEAD_BEEF_CAFE_F00D);
        check_eq("write_no_update", rdata, 64'h0);
        access(1'b1, 1'b0, 16'h0010, 64'h0);
        check_eq("wr_rd_0010", rdata, 64'hDEAD_BEEF_CAFE_F00D);

        access(1'b0, 1'b1, 16'h0010, 64'h1111_1111_1111_1111);
        check_eq("me0_hold", rdata, 64'hDEAD_BEEF_CAFE_F00D);
        access(1'b1, 1'b0, 16'h0010, 64'h0);
        check_eq("me0_no_write", rdata, 64'hDEAD_BEEF_CAFE_F00D);

        access(1'b1, 1'b1, 16'h0000, 64'hA5A5_A5A5_A5A5_A5A5);
        access(1'b1, 1'b1, 16'hFFFF, 64'h5A5A_5A5A_5A5A_5A5A);
        access(1'b1, 1'b0, 16'h0000, 64'h0);
        check_eq("rd_0000", rdata, 64'hA5A5_A5A5_A5A5_A5A5);
        access(1'b1, 1'b0, 16'hFFFF, 64'h0);
        check_eq("rd_ffff", rdata, 64'h5A5A_5A5A_5A5A_5A5A);
        access(1'b1, 1'b0, 16'h0000, 64'h0);
        check_eq("rd_0000_again", rdata, 64'hA5A5_A5A5_A5A5_A5A5);

        access(1'b1, 1'b1, 16'h0001, 64'h0123_4567_89AB_CDEF);
        check_eq("wr_no_disturb", rdata, 64'hA5A5_A5A5_A5A5_A5A5);
        access(1'b1, 1'b0, 16'h0001, 64'h0);
        check_eq("rd_0001", rdata, 64'h0123_4567_89AB_CDEF);

        access(1'b1, 1'b1, 16'h0020, 64'h1);
        check_eq("wr_0020_hold", rdata, 64'h0123_4567_89AB_CDEF);

        // Read of 0x20 in flight when reset drops; the access must be dropped.
        me   = 1'b1;
        wen  = 1'b0;
        addr = 16'h0020;
        #3;
        reset = 1'b0;
        #1;
        check_eq("midop_async", rdata, 64'h0);
        @(posedge clk);
        #1;
        check_eq("midop_dropped", rdata, 64'h0);
        me    = 1'b0;
        reset = 1'b1;

        access(1'b1, 1'b0, 16'h0020, 64'h0);
        check_eq("retain_0020", rdata, 64'h1);
        access(1'b1, 1'b0, 16'h0010, 64'h0);
        check_eq("retain_0010", rdata, 64'hDEAD_BEEF_CAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modport_ram.md
Name: modport_ram

Overview:
- Single-port synchronous RAM (SPRAM), 64-bit word, 16-bit word address.
- Driven through the team's memory interface: addr, wen, me, wdata in; rdata out.
- Leaf storage block for the SPRAM verification environment: driver and monitor sample on posedge clk.
- One access per cycle, read or write, gated by memory enable.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 64, data word width in bits.
- DEPTH, 65536, number of words implemented (must be <= 2**ADDR_W).

Ports:
- clk  input  1  system clock; all activity on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  word address of the access.
- wen  input  1  1 = write, 0 = read (valid only when me=1).
- me  input  1  memory enable; 0 = no operation.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  registered read data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0): rdata clears to 0 immediately, with no clock required. The storage array is NOT cleared; its contents are undefined until written. While reset is low, writes and reads are blocked.
- Reset release: the first access is accepted on the first posedge with reset=1.
- me=0: no access. Array unchanged; rdata holds its last value.
- Write (me=1, wen=1) at posedge: mem[addr] <= wdata. rdata holds its previous value (no write-through).
- Read (me=1, wen=0) at posedge: rdata <= mem[addr]. Read latency is 1 cycle: the value is visible after the sampling edge and stays stable until the next read or reset.
- Consecutive accesses:
  - Write then read of the same address on the next cycle returns the new data.
  - Back-to-back reads at different addresses update rdata every cycle.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W): write is ignored; read returns 0.
- Reset asserted mid-operation: any access in that cycle is dropped and rdata forces to 0. Array locations written before reset keep their data.
- No X propagation from control: me/wen must be known at the sampling edge. X on me is treated as no access (assertion flags it).
- Interface timing: the bench drives outputs 1 time unit after posedge and samples 1 time unit before. The RAM must produce rdata with pure register-out timing, with no combinational path from inputs to rdata.

Decomposition:
- Shared package spram_pkg holds:
  - ADDR_W = 16, DATA_W = 64, DEPTH = 65536.
  - typedefs addr_t (logic [ADDR_W-1:0]) and data_t (logic [DATA_W-1:0]).
  - enum op_e {OP_IDLE, OP_READ, OP_WRITE}, shared by driver/monitor/scoreboard.
- One sub-module, spram_core: the bare array plus write/read ports, synthesisable to a memory macro or inferred RAM.
- modport_ram wraps spram_core with the enable/decode logic, range check, rdata register with async reset, and assertions.

Test Plan:
- Reset: assert reset=0 with rdata previously 64'hFFFF_FFFF_FFFF_FFFF, no clock edge -> rdata == 0 immediately. Release -> rdata stays 0 until the first read.
- Write/read: write 64'hDEAD_BEEF_CAFE_F00D to addr 16'h0010, then read addr 16'h0010 -> rdata == 64'hDEAD_BEEF_CAFE_F00D one cycle after the read edge.
- Enable gating: with me=0, wen=1, wdata=64'h1111_1111_1111_1111, addr 16'h0010, then read 16'h0010 -> rdata still 64'hDEAD_BEEF_CAFE_F00D. With me=0 only, rdata is unchanged.
- Boundaries:
  - Write 64'hA5A5_A5A5_A5A5_A5A5 to 16'h0000 and 64'h5A5A_5A5A_5A5A_5A5A to 16'hFFFF.
  - Read both -> each returns its own value; no aliasing.
- Write does not disturb rdata: read 16'h0000 (rdata = 64'hA5A5...), then write 16'h0001 = 64'h0123_4567_89AB_CDEF -> rdata stays 64'hA5A5_A5A5_A5A5_A5A5.
- Mid-operation reset:
  - Write 64'h1 to 16'h0020.
  - Start a read of 16'h0020 and pulse reset=0 between edges -> rdata == 0.
  - After release, read 16'h0020 -> 64'h1 (array retained).
